mem_port_arbiter: RTL

- Arbitrates one single-port synchronous memory (BIOS/IMEM-style block RAM) between the fetch stage and the memory stage of the 3-stage RISC-V core.
- Runs the memory access sequence: accept, wait for read latency, capture, return.
- Produces the pipeline stall used by the hazard/pc_sel logic while a requester waits.
- Prevents fetch starvation under back-to-back data traffic.

---
 rtl/mem_port_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous RAM between instruction
// fetch and the data (memory) stage. Each accepted read is followed by a
// MEM_LAT-cycle wait, a capture into the owner's rdata register, and a one-cycle
// rvalid pulse. A starvation counter makes sure that a fetch still wins after
// STARVE_MAX data grants in a row.
//
// Handshake: a requester raises req with its address (and store data) and
// holds them stable until the cycle in which its ack is high. The ack is
// combinational and marks the only cycle in which the memory is driven for that
// request. Read data comes back later as an rvalid pulse. There is no
// backpressure on rvalid.
module mem_port_arbiter #(
  parameter int AWIDTH     = 12,
  parameter int DWIDTH     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [AWIDTH-1:0]   if_addr,
  output logic                if_ack,
  output logic                if_rvalid,
  output logic [DWIDTH-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [AWIDTH-1:0]   d_addr,
  input  logic [DWIDTH-1:0]   d_wdata,
  input  logic [DWIDTH/8-1:0] d_wmask,
  output logic                d_ack,
  output logic                d_rvalid,
  output logic [DWIDTH-1:0]   d_rdata,
  output logic                mem_en,
  output logic [DWIDTH/8-1:0] mem_we,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic [DWIDTH-1:0]   mem_din,
  input  logic [DWIDTH-1:0]   mem_dout,
  output logic                stall
);

  localparam int CW = $clog2(MEM_LAT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAT_INIT   = CW'(MEM_LAT);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          owner, owner_nxt;   // 1: data stage owns the outstanding read
  logic [SW-1:0] starve_cnt, starve_nxt;

  logic window, complete, fetch_wins, grant_if, grant_d, read_grant;

  // Arbitration, memory drive and next-state logic
  always_comb begin
    complete   = (state == WAIT) && (cnt == CNT_ONE);
    window     = (state == IDLE) || complete;
    fetch_wins = if_req && (!d_req || (starve_cnt == STARVE_SAT));
    grant_if   = window && fetch_wins;
    grant_d    = window && d_req && !fetch_wins;
    read_grant = grant_if || (grant_d && !d_we);

    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    if (read_grant) begin
      state_nxt = WAIT;
      cnt_nxt   = LAT_INIT;
      owner_nxt = grant_d;
    end else if (state == WAIT) begin
      cnt_nxt = cnt - CNT_ONE;
      if (complete) state_nxt = IDLE;
    end

    // A fetch that is not waiting, or a fetch grant, resets the starvation count.
    starve_nxt = starve_cnt;
    if (!if_req || grant_if) starve_nxt = '0;
    else if (grant_d && (starve_cnt != STARVE_SAT)) starve_nxt = starve_cnt + 1'b1;
  end

  assign if_ack   = grant_if;
  assign d_ack    = grant_d;
  assign mem_en   = grant_if || grant_d;
  assign mem_addr = grant_if ? if_addr : d_addr;
  assign mem_din  = d_wdata;
  assign mem_we   = (grant_d && d_we) ? d_wmask : '0;
  assign stall    = (if_req && !grant_if) || (d_req && !grant_d);

  // State register, latency counter, read owner and starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Capture mem_dout for the owner in the completion cycle; rvalid follows for one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if (complete) begin
        if (owner) begin
          d_rdata  <= mem_dout;
          d_rvalid <= 1'b1;
        end else begin
          if_rdata  <= mem_dout;
          if_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule
